// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One bit per cycle: shift-add multiply, restoring divide. Divide-by-zero
// and signed overflow skip the iterations and go straight to the fix-up step.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WIDTH-1:0]   b_q;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;    // product, or {remainder, dividend/quotient}
  logic               s1_q, s2_q;
  logic [CNT_W-1:0]   cnt_q;

  // Request decode: signedness, magnitudes and the two divide special cases
  logic             sgn1, sgn2, neg1, neg2, is_div, div_zero, div_ovf, special;
  logic [WIDTH-1:0] mag1, mag2;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sgn1     = (select != 3'b011) && (select != 3'b101) && (select != 3'b111);
    sgn2     = sgn1 && (select != 3'b010);
    neg1     = sgn1 && data1[WIDTH-1];
    neg2     = sgn2 && data2[WIDTH-1];
    mag1     = neg1 ? -data1 : data1;
    mag2     = neg2 ? -data2 : data2;
    is_div   = select[2];
    div_zero = is_div && (data2 == '0);
    div_ovf  = ((select == 3'b100) || (select == 3'b110)) &&
               (data1 == {1'b1, {(WIDTH-1){1'b0}}}) && (data2 == '1);
    special  = div_zero || div_ovf;
  end

  // One iteration of the shift-add multiply or restoring divide
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!op_q[2]) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, fix_result;

  always_comb begin
    prod = (s1_q ^ s2_q) ? -acc_q : acc_q;
    quot = (s1_q ^ s2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = s1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    unique case (op_q)
      3'b000:         fix_result = prod[WIDTH-1:0];
      3'b100, 3'b101: fix_result = quot;
      3'b110, 3'b111: fix_result = rem;
      default:        fix_result = prod[2*WIDTH-1:WIDTH];
    endcase
  end

  // Next-state logic; kill overrides everything, including a start
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = special ? FIX : CALC;
      CALC:    if (cnt_q == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // State register and registered busy flag
  // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Datapath: latch request, iterate, register the fixed-up result
  // NOTE: the datapath registers are flops, not a memory, so they take the reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      tag_q        <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      cnt_q        <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      tag_out      <= '0;
    end else begin
      result_valid <= 1'b0;
      if (!kill) begin
        unique case (state)
          IDLE: if (start) begin
            op_q  <= select;
            tag_q <= tag_in;
            cnt_q <= '0;
            // Special cases preload the final answer with no sign fix-up
            s1_q  <= neg1 && !special;
            s2_q  <= neg2 && !special;
            if (div_zero) begin
              acc_q <= {data1, {WIDTH{1'b1}}};
              b_q   <= '0;
            end else if (div_ovf) begin
              acc_q <= {{WIDTH{1'b0}}, data1};
              b_q   <= '0;
            end else if (is_div) begin
              acc_q <= {{WIDTH{1'b0}}, mag1};
              b_q   <= mag2;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, mag2};
              b_q   <= mag1;
            end
          end
          CALC: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
          end
          FIX: begin
            result       <= fix_result;
            tag_out      <= tag_q;
            result_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        start = 1'b0, kill = 1'b0;
  logic [2:0]  select = '0;
  logic [31:0] data1 = '0, data2 = '0;
  logic [4:0]  tag_in = '0;
  logic        busy, result_valid;
  logic [31:0] result;
  logic [4:0]  tag_out;

  muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .select(select), .data1(data1),
    .data2(data2), .tag_in(tag_in), .kill(kill), .busy(busy),
    .result_valid(result_valid), .result(result), .tag_out(tag_out)
  );

  // WIDTH=8 instance
  logic       start8 = 1'b0, kill8 = 1'b0;
  logic [2:0] select8 = '0;
  logic [7:0] data1_8 = '0, data2_8 = '0;
  logic [2:0] tag_in8 = '0;
  logic       busy8, result_valid8;
  logic [7:0] result8;
  logic [2:0] tag_out8;

  muldiv_unit #(.WIDTH(8), .TAG_W(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .select(select8), .data1(data1_8),
    .data2(data2_8), .tag_in(tag_in8), .kill(kill8), .busy(busy8),
    .result_valid(result_valid8), .result(result8), .tag_out(tag_out8)
  );

  int checks = 0;
  int failures = 0;

  // Issue one op on the 32-bit unit and wait (bounded) for its result
  task automatic do_op32(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, output logic [31:0] res,
                         output logic [4:0] tgo, output int lat, output logic bsy);
    select = sel; data1 = a; data2 = b; tag_in = tg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bsy = busy;
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    tgo = tag_out;
  endtask

  task automatic do_op8(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] tg, output logic [7:0] res,
                        output logic [2:0] tgo, output int lat);
    select8 = sel; data1_8 = a; data2_8 = b; tag_in8 = tg; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!result_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result8;
    tgo = tag_out8;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, result_valid, result, tag_out} !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b valid=%b result=%h tag=%h, expected all 0",
               busy, result_valid, result, tag_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [4:0] t; int lat; logic bsy;
    do_op32(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd4, r, t, lat, bsy);
    checks++;
    if (bsy !== 1'b1) begin failures++; $display("FAIL mul_busy: got %b expected 1", bsy); end
    checks++;
    if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++;
    if (t !== 5'd4) begin failures++; $display("FAIL mul_tag: got %0d expected 4", t); end
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFF_FFEB) begin
      failures++;
      $display("FAIL mul_valid_pulse: got valid=%b busy=%b result=%h expected 0 0 ffffffeb",
               result_valid, busy, result);
    end
    do_op32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, r, t, lat, bsy);
    checks++;
    if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu: got %h expected fffffffe", r); end
    do_op32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, r, t, lat, bsy);
    checks++;
    if (r !== 32'h0000_0000) begin failures++; $display("FAIL mulh: got %h expected 00000000", r); end
    do_op32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, r, t, lat, bsy);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu: got %h expected ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; logic [4:0] t; int lat; logic bsy;
    logic [2:0]  sels [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as   [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
    logic [31:0] exps [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6, 32'd2};
    for (int i = 0; i < 4; i++) begin
      do_op32(sels[i], as[i], 32'd3, 5'(10 + i), r, t, lat, bsy);
      checks++;
      if (r !== exps[i] || t !== 5'(10 + i) || lat != 33) begin
        failures++;
        $display("FAIL div_case%0d: got result=%h tag=%0d lat=%0d expected %h %0d 33",
                 i, r, t, lat, exps[i], 10 + i);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] r; logic [4:0] t; int lat; logic bsy;
    logic [2:0]  sels [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      do_op32(sels[i], as[i], bs[i], 5'(20 + i), r, t, lat, bsy);
      checks++;
      if (r !== exps[i] || t !== 5'(20 + i) || lat != 1) begin
        failures++;
        $display("FAIL special_case%0d: got result=%h tag=%0d lat=%0d expected %h %0d 1",
                 i, r, t, lat, exps[i], 20 + i);
      end
    end
  endtask

  task automatic test_start_busy();
    int lat; int extra;
    select = 3'b101; data1 = 32'd20; data2 = 32'd3; tag_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    select = 3'b000; data1 = 32'd1; data2 = 32'd1; tag_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (result !== 32'd6 || tag_out !== 5'd3 || lat != 33) begin
      failures++;
      $display("FAIL start_busy_result: got result=%h tag=%0d lat=%0d expected 6 3 33",
               result, tag_out, lat);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid) extra++;
    end
    checks++;
    if (extra != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_busy_no_second: got %0d extra valids busy=%b expected 0 0", extra, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic [4:0] t; int lat; logic bsy;
    do_op32(3'b111, 32'd20, 32'd3, 5'd1, r, t, lat, bsy);
    checks++;
    if (r !== 32'd2) begin failures++; $display("FAIL b2b_first: got %h expected 2", r); end
    do_op32(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd2, r, t, lat, bsy);
    checks++;
    if (r !== 32'hFFFF_FFFA || t !== 5'd2 || lat != 33) begin
      failures++;
      $display("FAIL b2b_second: got result=%h tag=%0d lat=%0d expected fffffffa 2 33", r, t, lat);
    end
  endtask

  task automatic test_kill();
    logic [31:0] r; logic [4:0] t; int lat; logic bsy; int extra;
    logic [31:0] prev;
    prev = result;
    select = 3'b000; data1 = 32'd9; data2 = 32'd9; tag_in = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== prev) begin
      failures++;
      $display("FAIL kill_state: got busy=%b valid=%b result=%h expected 0 0 %h",
               busy, result_valid, result, prev);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL kill_no_valid: got %0d valids expected 0", extra); end
    do_op32(3'b101, 32'd100, 32'd7, 5'd9, r, t, lat, bsy);
    checks++;
    if (r !== 32'd14 || t !== 5'd9 || lat != 33) begin
      failures++;
      $display("FAIL kill_recover: got result=%h tag=%0d lat=%0d expected e 9 33", r, t, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] t; int lat; logic bsy;
    select = 3'b011; data1 = 32'h1234_5678; data2 = 32'd3; tag_in = 5'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, result_valid, result, tag_out} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b valid=%b result=%h tag=%h expected all 0",
               busy, result_valid, result, tag_out);
    end
    #1;
    rst = 1'b0;
    do_op32(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd12, r, t, lat, bsy);
    checks++;
    if (r !== 32'hFFFF_FFEB || t !== 5'd12 || lat != 33) begin
      failures++;
      $display("FAIL reset_recover: got result=%h tag=%0d lat=%0d expected ffffffeb 12 33", r, t, lat);
    end
  endtask

  task automatic test_width8();
    logic [7:0] r; logic [2:0] t; int lat;
    do_op8(3'b000, 8'h7F, 8'h02, 3'd5, r, t, lat);
    checks++;
    if (r !== 8'hFE || t !== 3'd5 || lat != 9) begin
      failures++;
      $display("FAIL w8_mul: got result=%h tag=%0d lat=%0d expected fe 5 9", r, t, lat);
    end
    do_op8(3'b101, 8'hFF, 8'h10, 3'd2, r, t, lat);
    checks++;
    if (r !== 8'h0F || t !== 3'd2 || lat != 9) begin
      failures++;
      $display("FAIL w8_divu: got result=%h tag=%0d lat=%0d expected 0f 2 9", r, t, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_busy();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on WIDTH-bit operands, one bit per cycle, with a start/valid handshake. It sits beside the single-cycle ALU in the EX stage. The hazard unit holds the pipeline on BUSY, and the result plus its destination tag return on RESULT_VALID. It provides RISC-V-exact divide-by-zero/overflow results and a flush input, which the combinational ALU does not.

## Interface
- WIDTH, 32: operand/result width (≥4, even).
- TAG_W, 5: width of tag carried alongside the operation (destination register).
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; accepted only when BUSY=0.
- SELECT  in  3  op (funct3 encoding): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  in  WIDTH  rs1 operand (dividend / multiplicand).
- DATA2  in  WIDTH  rs2 operand (divisor / multiplier).
- TAG_IN  in  TAG_W  tag latched with the request.
- KILL  in  1  synchronous flush; abandons any op in flight.
- BUSY  out  1  op in progress; START ignored.
- RESULT_VALID  out  1  one-cycle pulse, RESULT/TAG_OUT valid.
- RESULT  out  WIDTH  result, held until next RESULT_VALID.
- TAG_OUT  out  TAG_W  tag of RESULT, held with RESULT.

## Operation
- States: IDLE, CALC, FIX. Reset → IDLE; BUSY=0, RESULT_VALID=0, RESULT=0, TAG_OUT=0, all internal registers 0.
- IDLE, START=1 at edge E0: latch SELECT, TAG_IN, |DATA1|, |DATA2| (magnitude only if operand is signed for that op), the sign flags, and the counter=0.
- Signedness: MUL/MULH/DIV/REM both signed. MULHSU: DATA1 signed, DATA2 unsigned. MULHU/DIVU/REMU: both unsigned. MUL low half is sign-independent.
- Special cases, detected at E0 and skipping CALC (→FIX directly):
  - Divide by zero: quotient = all ones; remainder = DATA1.
  - Signed overflow (DIV/REM, DATA1 = 1 followed by WIDTH-1 zeros, DATA2 = all ones): quotient = DATA1; remainder = 0.
- Otherwise → CALC, which runs WIDTH iterations:
  - Multiply: shift-add into a 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
- After the last iteration → FIX.
- FIX:
  - Negate the magnitude result if required: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1 (divisor ≠ 0).
  - Select the low half (MUL) or high half (MULH*) of the 2·WIDTH product, or the quotient/remainder.
  - Register RESULT and TAG_OUT, pulse RESULT_VALID, → IDLE.
- KILL=1 at any edge: → IDLE, BUSY=0, no RESULT_VALID, RESULT/TAG_OUT unchanged. KILL has priority over START at the same edge.
- START while BUSY=1: ignored, no effect on op in flight.

## Timing
- Normal op: START sampled at E0 → BUSY high after E0; CALC on E1..E_WIDTH; FIX at E_(WIDTH+1). Effects of FIX at E_(WIDTH+1):
  - RESULT_VALID=1 and BUSY=0.
  - RESULT_VALID lasts exactly one cycle.
  - Latency: WIDTH+1 edges (33 for WIDTH=32).
- Special case: FIX at E1; RESULT_VALID high after E1 (latency 1).
- Back-to-back: START may be accepted at the edge ending the RESULT_VALID cycle (state IDLE). There are no bubbles beyond FIX.
- RESET asserted mid-op: immediate (asynchronous) return to the reset values. After deassertion, the first START is accepted at the next edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=32:
  - MUL 7×(−3) → RESULT=0xFFFFFFEB, valid 33 edges after START.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULH same operands → 0x00000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA. REM −20/3 → 0xFFFFFFFE. DIVU 20/3 → 6. REMU 20/3 → 2. Each with TAG_OUT = TAG_IN.
- Corner cases, each valid 1 edge after START:
  - DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Handshake:
  - START pulsed during BUSY with different operands → the first op's result is unaffected and no second valid appears.
  - Back-to-back START in the valid cycle → second result 33 edges later.
- KILL at CALC cycle 10 → no RESULT_VALID, BUSY=0 next cycle, RESULT holds its previous value. A new START then completes correctly.
- RESET asserted mid-CALC (between edges) → BUSY/RESULT_VALID/RESULT 0 immediately. Repeat with WIDTH=8, TAG_W=3: MUL 0x7F×0x02 → 0xFE, DIVU 0xFF/0x10 → 0x0F, latency 9.
